// File: rtl/ysyx_22040127_muldiv_seq_if.sv
// ysyx_22040127_muldiv_seq_if
// Handshake bundle between the execute stage and the iterative M-extension
// unit.
//   in_valid/in_ready   : request handshake (funct3, word flag, rs1, rs2)
//   flush               : abandon whatever op is in flight
//   out_valid/out_ready : result handshake (out_result)
//   busy                : stall request toward the execute stage
// The master modport is the requester side and the slave modport is the unit.
interface ysyx_22040127_muldiv_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_funct3;
    logic        in_word;
    logic [63:0] in_src1;
    logic [63:0] in_src2;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic        busy;

    modport master (
        output in_valid, in_funct3, in_word, in_src1, in_src2, flush, out_ready,
        input  in_ready, out_valid, out_result, busy
    );

    modport slave (
        input  in_valid, in_funct3, in_word, in_src1, in_src2, flush, out_ready,
        output in_ready, out_valid, out_result, busy
    );
endinterface

// File: rtl/ysyx_22040127_muldiv_seq.sv
// ysyx_22040127_muldiv_seq
// Iterative RV64 M-extension unit (mul/mulh/mulhsu/mulhu/div/divu/rem/remu
// and their *W forms). One op is accepted in IDLE, runs ITER shift-add or
// restoring-divide steps in CALC, and waits in DONE until the result is taken.
// Divide-by-zero and signed overflow finish straight from IDLE to DONE.
//   clk : rising-edge clock
//   rst : synchronous, active-high reset
//   io  : slave side of ysyx_22040127_muldiv_seq_if (request, result,
//         flush and busy signals)
module ysyx_22040127_muldiv_seq #(
    parameter int XLEN = 64,
    parameter int ITER = 64
) (
    input logic                     clk,
    input logic                     rst,
    ysyx_22040127_muldiv_seq_if.slave io
);
    localparam int CNT_W = $clog2(ITER) + 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  counter_q, counter_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              isDiv_q, isDiv_d;
    logic              isRem_q, isRem_d;
    logic              wantHigh_q, wantHigh_d;
    logic              isWord_q, isWord_d;
    logic              negate_q, negate_d;

    // Word results keep bits [31:0] and sign-extend them.
    function automatic logic [XLEN-1:0] fixWord(input logic isWord, input logic [XLEN-1:0] value);
        fixWord = isWord ? {{32{value[31]}}, value[31:0]} : value;
    endfunction

    // Request decode: signedness of each operand, width-adjusted operands,
    // their magnitudes, and the sign fix-up needed on the final result.
    logic            isDivIn, isRemIn, signed1, signed2;
    logic [XLEN-1:0] srcA, srcB, magA, magB;
    logic            negA, negB, divZero, divOvf, trivial;
    logic [XLEN-1:0] trivialRaw, trivialResult;

    always_comb begin
        isDivIn = io.in_funct3[2];
        isRemIn = io.in_funct3[2] & io.in_funct3[1];
        signed1 = 1'b0;
        signed2 = 1'b0;
        if (isDivIn) begin
            signed1 = ~io.in_funct3[0];
            signed2 = ~io.in_funct3[0];
        end else if (!io.in_word) begin
            // Only the high-half multiplies care about operand signs.
            case (io.in_funct3[1:0])
                2'b01:   begin signed1 = 1'b1; signed2 = 1'b1; end
                2'b10:   begin signed1 = 1'b1; signed2 = 1'b0; end
                default: begin signed1 = 1'b0; signed2 = 1'b0; end
            endcase
        end

        srcA = io.in_src1;
        srcB = io.in_src2;
        if (io.in_word) begin
            srcA = signed1 ? {{32{io.in_src1[31]}}, io.in_src1[31:0]} : {32'b0, io.in_src1[31:0]};
            srcB = signed2 ? {{32{io.in_src2[31]}}, io.in_src2[31:0]} : {32'b0, io.in_src2[31:0]};
        end
        negA = signed1 & srcA[XLEN-1];
        negB = signed2 & srcB[XLEN-1];
        magA = negA ? (~srcA + 1'b1) : srcA;
        magB = negB ? (~srcB + 1'b1) : srcB;

        // Trivial divides are judged at the operand width of the request.
        if (io.in_word) begin
            divZero = (io.in_src2[31:0] == 32'h0);
            divOvf  = signed1 & (io.in_src1[31:0] == 32'h8000_0000) & (io.in_src2[31:0] == 32'hFFFF_FFFF);
        end else begin
            divZero = (io.in_src2 == '0);
            divOvf  = signed1 & (io.in_src1 == {1'b1, {(XLEN-1){1'b0}}}) & (io.in_src2 == '1);
        end
        trivial = isDivIn & (divZero | divOvf);
        if (divZero) begin
            trivialRaw = isRemIn ? io.in_src1 : '1;
        end else begin
            trivialRaw = isRemIn ? '0 : io.in_src1;
        end
        trivialResult = fixWord(io.in_word, trivialRaw);
    end

    // One datapath step. Multiply: acc holds {partial high, remaining
    // multiplier}; add opnd when the multiplier LSB is set, then shift right.
    // Divide: acc holds {partial remainder, dividend/quotient}; shift left and
    // subtract the divisor whenever the shifted remainder covers it.
    logic [XLEN:0]     mulSum;
    logic [XLEN:0]     remShift;
    logic [XLEN-1:0]   remSub;
    logic [2*XLEN-1:0] accStep;

    always_comb begin
        mulSum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
        remShift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        remSub   = XLEN'(remShift - {1'b0, opnd_q});
        if (isDiv_q) begin
            if (remShift >= {1'b0, opnd_q}) begin
                accStep = {remSub, acc_q[XLEN-2:0], 1'b1};
            end else begin
                accStep = {acc_q[2*XLEN-2:0], 1'b0};
            end
        end else begin
            if (acc_q[0]) begin
                accStep = {mulSum, acc_q[XLEN-1:1]};
            end else begin
                accStep = {1'b0, acc_q[2*XLEN-1:1]};
            end
        end
    end

    // Final result built from the last step's output so it can be registered
    // on the same edge that moves the FSM to DONE.
    logic [2*XLEN-1:0] prodSigned;
    logic [XLEN-1:0]   quotient, remainder, finalRaw, finalResult;

    always_comb begin
        prodSigned = negate_q ? (~accStep + 1'b1) : accStep;
        quotient   = negate_q ? (~accStep[XLEN-1:0] + 1'b1) : accStep[XLEN-1:0];
        remainder  = negate_q ? (~accStep[2*XLEN-1:XLEN] + 1'b1) : accStep[2*XLEN-1:XLEN];
        if (isDiv_q) begin
            finalRaw = isRem_q ? remainder : quotient;
        end else begin
            finalRaw = wantHigh_q ? prodSigned[2*XLEN-1:XLEN] : prodSigned[XLEN-1:0];
        end
        finalResult = fixWord(isWord_q, finalRaw);
    end

    // Next-state logic. Flush beats both the accept and the result handshake.
    always_comb begin
        state_d    = state_q;
        counter_d  = counter_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        result_d   = result_q;
        isDiv_d    = isDiv_q;
        isRem_d    = isRem_q;
        wantHigh_d = wantHigh_q;
        isWord_d   = isWord_q;
        negate_d   = negate_q;

        if (io.flush) begin
            state_d   = IDLE;
            counter_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (io.in_valid) begin
                        isDiv_d    = isDivIn;
                        isRem_d    = isRemIn;
                        wantHigh_d = ~isDivIn & ~io.in_word & (io.in_funct3[1:0] != 2'b00);
                        isWord_d   = io.in_word;
                        negate_d   = isRemIn ? negA : (negA ^ negB);
                        acc_d      = {{XLEN{1'b0}}, (isDivIn ? magA : magB)};
                        opnd_d     = isDivIn ? magB : magA;
                        counter_d  = '0;
                        if (trivial) begin
                            result_d = trivialResult;
                            state_d  = DONE;
                        end else begin
                            state_d  = CALC;
                        end
                    end
                end
                CALC: begin
                    acc_d     = accStep;
                    counter_d = counter_q + 1'b1;
                    if (counter_q == CNT_W'(ITER - 1)) begin
                        result_d  = finalResult;
                        counter_d = '0;
                        state_d   = DONE;
                    end
                end
                DONE: begin
                    if (io.out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State register with synchronous reset clearing the whole datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            counter_q  <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            result_q   <= '0;
            isDiv_q    <= 1'b0;
            isRem_q    <= 1'b0;
            wantHigh_q <= 1'b0;
            isWord_q   <= 1'b0;
            negate_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            counter_q  <= counter_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            result_q   <= result_d;
            isDiv_q    <= isDiv_d;
            isRem_q    <= isRem_d;
            wantHigh_q <= wantHigh_d;
            isWord_q   <= isWord_d;
            negate_q   <= negate_d;
        end
    end

    assign io.in_ready   = (state_q == IDLE) & ~rst;
    assign io.busy       = (state_q != IDLE);
    assign io.out_valid  = (state_q == DONE);
    assign io.out_result = result_q;

endmodule

// File: tb/tb_ysyx_22040127_muldiv_seq.sv
// tb_ysyx_22040127_muldiv_seq
// Directed bench for the iterative M-extension unit. Expected results come
// from a plain-arithmetic model of the RV64 M rules, pinned by literals.
module tb_ysyx_22040127_muldiv_seq;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ysyx_22040127_muldiv_seq_if io ();

    ysyx_22040127_muldiv_seq #(
        .XLEN(64),
        .ITER(64)
    ) dut (
        .clk(clk),
        .rst(rst),
        .io (io)
    );

    int          testsRun    = 0;
    int          testsFailed = 0;
    logic [63:0] expResult   = '0;
    bit          expectNone  = 1'b1;

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // Reference result straight from the RV64 M definitions.
    function automatic logic [63:0] modelResult(input logic [2:0] f, input logic w,
                                                input logic [63:0] a, input logic [63:0] b);
        logic [127:0] p;
        logic [31:0]  p32, ua32, ub32, uq32, ur32;
        logic [63:0]  r, uq, ur;
        int           sa32, sb32, q32, rm32;
        longint       sa, sb, q, rm;
        r = '0;
        if (!f[2]) begin
            if (w) begin
                p32 = a[31:0] * b[31:0];
                r   = sext32(p32);
            end else begin
                case (f[1:0])
                    2'b00: r = a * b;
                    2'b01: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; r = p[127:64]; end
                    2'b10: begin p = {{64{a[63]}}, a} * {64'b0, b};       r = p[127:64]; end
                    default: begin p = {64'b0, a} * {64'b0, b};           r = p[127:64]; end
                endcase
            end
        end else if (w) begin
            if (!f[0]) begin
                sa32 = $signed(a[31:0]);
                sb32 = $signed(b[31:0]);
                if (sb32 == 0) begin
                    q32 = -1; rm32 = sa32;
                end else if (sa32 == 32'sh8000_0000 && sb32 == -1) begin
                    q32 = sa32; rm32 = 0;
                end else begin
                    q32 = sa32 / sb32; rm32 = sa32 % sb32;
                end
                r = sext32(f[1] ? 32'(rm32) : 32'(q32));
            end else begin
                ua32 = a[31:0];
                ub32 = b[31:0];
                if (ub32 == 0) begin
                    uq32 = '1; ur32 = ua32;
                end else begin
                    uq32 = ua32 / ub32; ur32 = ua32 % ub32;
                end
                r = sext32(f[1] ? ur32 : uq32);
            end
        end else begin
            if (!f[0]) begin
                sa = $signed(a);
                sb = $signed(b);
                if (sb == 0) begin
                    q = -1; rm = sa;
                end else if (a == 64'h8000_0000_0000_0000 && sb == -1) begin
                    q = sa; rm = 0;
                end else begin
                    q = sa / sb; rm = sa % sb;
                end
                r = f[1] ? 64'(rm) : 64'(q);
            end else begin
                if (b == 0) begin
                    uq = '1; ur = a;
                end else begin
                    uq = a / b; ur = a % b;
                end
                r = f[1] ? ur : uq;
            end
        end
        return r;
    endfunction

    // Divide by zero or signed overflow at the operand width finishes in one cycle.
    function automatic bit modelTrivial(input logic [2:0] f, input logic w,
                                        input logic [63:0] a, input logic [63:0] b);
        if (!f[2]) return 1'b0;
        if (w) return (b[31:0] == 32'h0) ||
                      (!f[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
        return (b == 64'h0) || (!f[0] && a == 64'h8000_0000_0000_0000 && b == '1);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
        testsRun++;
        if (got !== want) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    // Whenever a result is presented it must match the model, with the unit
    // still busy and refusing new requests.
    always @(negedge clk) begin
        if (!rst && io.out_valid === 1'b1) begin
            testsRun++;
            if (expectNone) begin
                testsFailed++;
                $display("[TB] FAIL no_result_expected: got out_valid=1 result=%h, required out_valid=0", io.out_result);
            end else if (io.out_result !== expResult || io.busy !== 1'b1 || io.in_ready !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL cycle_result: got result=%h busy=%b in_ready=%b, required result=%h busy=1 in_ready=0",
                         io.out_result, io.busy, io.in_ready, expResult);
            end
        end
    end

    // Issue one op, check latency/busy/result, hold out_ready low for
    // holdCycles, then take the result and confirm the unit is idle again.
    task automatic applyStimulus(input string name, input logic [2:0] f, input logic w,
                                 input logic [63:0] a, input logic [63:0] b,
                                 input logic [63:0] lit, input bit useLit, input int holdCycles);
        logic [63:0] m;
        int          expLat;
        int          cycles;
        bit          busyOk;
        bit          holdOk;
        m      = modelResult(f, w, a, b);
        expLat = modelTrivial(f, w, a, b) ? 1 : 65;
        if (useLit) checkOutput({name, "_model"}, m, lit);
        expResult  = m;
        expectNone = 1'b0;
        @(negedge clk);
        io.in_funct3 = f;
        io.in_word   = w;
        io.in_src1   = a;
        io.in_src2   = b;
        io.in_valid  = 1'b1;
        io.out_ready = 1'b0;
        checkOutput({name, "_in_ready"}, 64'(io.in_ready), 64'd1);
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
        cycles = 1;
        busyOk = 1'b1;
        while (io.out_valid !== 1'b1 && cycles < 200) begin
            if (io.busy !== 1'b1) busyOk = 1'b0;
            @(posedge clk);
            #1;
            cycles++;
        end
        if (io.busy !== 1'b1) busyOk = 1'b0;
        checkOutput({name, "_latency"}, 64'(cycles), 64'(expLat));
        checkOutput({name, "_busy"}, 64'(busyOk), 64'd1);
        checkOutput({name, "_result"}, io.out_result, useLit ? lit : m);
        holdOk = 1'b1;
        for (int k = 0; k < holdCycles; k++) begin
            @(posedge clk);
            #1;
            if (io.out_valid !== 1'b1 || io.out_result !== m || io.in_ready !== 1'b0) holdOk = 1'b0;
        end
        if (holdCycles > 0) checkOutput({name, "_hold"}, 64'(holdOk), 64'd1);
        io.out_ready = 1'b1;
        @(posedge clk);
        #1;
        io.out_ready = 1'b0;
        checkOutput({name, "_release"}, 64'({io.out_valid, io.busy, io.in_ready}), 64'b001);
    endtask

    // Start an op and abandon it at cycle abortAt with flush or reset.
    task automatic abortStimulus(input string name, input logic [2:0] f, input logic w,
                                 input logic [63:0] a, input logic [63:0] b,
                                 input int abortAt, input bit useReset);
        bit quietOk;
        expectNone = 1'b1;
        @(negedge clk);
        io.in_funct3 = f;
        io.in_word   = w;
        io.in_src1   = a;
        io.in_src2   = b;
        io.in_valid  = 1'b1;
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
        for (int k = 1; k < abortAt; k++) @(posedge clk);
        #1;
        checkOutput({name, "_inflight"}, 64'({io.out_valid, io.busy}), 64'b01);
        if (useReset) rst = 1'b1;
        else io.flush = 1'b1;
        @(posedge clk);
        #1;
        io.flush = 1'b0;
        if (useReset) begin
            checkOutput({name, "_in_reset"}, 64'({io.out_valid, io.busy, io.in_ready}), 64'b000);
            checkOutput({name, "_reset_result"}, io.out_result, 64'h0);
            rst = 1'b0;
            #1;
        end
        checkOutput({name, "_idle"}, 64'({io.out_valid, io.busy, io.in_ready}), 64'b001);
        quietOk = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            if (io.out_valid !== 1'b0 || io.busy !== 1'b0) quietOk = 1'b0;
        end
        checkOutput({name, "_quiet"}, 64'(quietOk), 64'd1);
        expectNone = 1'b0;
    endtask

    initial begin
        logic [2:0]  rf;
        logic        rw;
        logic [63:0] ra, rb;
        rst          = 1'b1;
        io.in_valid  = 1'b0;
        io.in_funct3 = 3'b000;
        io.in_word   = 1'b0;
        io.in_src1   = '0;
        io.in_src2   = '0;
        io.flush     = 1'b0;
        io.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_ctrl", 64'({io.out_valid, io.busy, io.in_ready}), 64'b000);
        checkOutput("reset_result", io.out_result, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("post_reset_ready", 64'(io.in_ready), 64'd1);

        applyStimulus("mul_7x-3", 3'b000, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 1'b1, 10);
        applyStimulus("mulhu_ones", 3'b011, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 0);
        applyStimulus("mulh_ones", 3'b001, 1'b0, '1, '1, 64'h0, 1'b1, 0);
        applyStimulus("mulhsu", 3'b010, 1'b0, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 0);
        applyStimulus("mulh_min", 3'b001, 1'b0, 64'h8000_0000_0000_0000, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 0);
        applyStimulus("mulhu_2p64", 3'b011, 1'b0, 64'h8000_0000_0000_0000, 64'd2, 64'h1, 1'b1, 0);
        applyStimulus("mulw", 3'b000, 1'b1, 64'h1234_5678_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 0);
        applyStimulus("div_by0", 3'b100, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 0);
        applyStimulus("rem_by0", 3'b110, 1'b0, 64'd5, 64'd0, 64'd5, 1'b1, 0);
        applyStimulus("divw_ovf", 3'b100, 1'b1, 64'h0000_0000_8000_0000, '1, 64'hFFFF_FFFF_8000_0000, 1'b1, 0);
        applyStimulus("divw_-7/2", 3'b100, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1, 0);
        applyStimulus("remw_-7/2", 3'b110, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 0);
        applyStimulus("divu_100/7", 3'b101, 1'b0, 64'd100, 64'd7, 64'd14, 1'b1, 0);
        applyStimulus("remu_100/7", 3'b111, 1'b0, 64'd100, 64'd7, 64'd2, 1'b1, 0);
        applyStimulus("div_-20/3", 3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 1'b1, 0);
        applyStimulus("rem_-20/3", 3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 0);
        applyStimulus("div_ovf", 3'b100, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1'b1, 0);
        applyStimulus("rem_ovf", 3'b110, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h0, 1'b1, 0);
        applyStimulus("remuw_by0", 3'b111, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0001_0000_0000, 64'hFFFF_FFFF_8000_0000, 1'b1, 0);

        // A request presented together with flush while idle must be dropped.
        expectNone = 1'b1;
        @(negedge clk);
        io.in_funct3 = 3'b000;
        io.in_word   = 1'b0;
        io.in_src1   = 64'd3;
        io.in_src2   = 64'd4;
        io.in_valid  = 1'b1;
        io.flush     = 1'b1;
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
        io.flush    = 1'b0;
        checkOutput("flush_idle_drop", 64'({io.busy, io.in_ready}), 64'b01);
        repeat (2) @(posedge clk);
        expectNone = 1'b0;

        abortStimulus("flush_div", 3'b100, 1'b0, 64'd1000, 64'd7, 30, 1'b0);
        applyStimulus("mul_after_flush", 3'b000, 1'b0, 64'd123456789, 64'd987654321, 64'd121932631112635269, 1'b1, 0);
        abortStimulus("reset_div", 3'b100, 1'b0, 64'd1000, 64'd7, 30, 1'b1);
        applyStimulus("mul_after_reset", 3'b000, 1'b0, 64'd123456789, 64'd987654321, 64'd121932631112635269, 1'b1, 0);

        for (int i = 0; i < 12; i++) begin
            rf = 3'($urandom_range(0, 7));
            rw = 1'($urandom_range(0, 1));
            ra = {$urandom, $urandom};
            rb = (i % 3 == 0) ? 64'($urandom_range(0, 3)) : {$urandom, $urandom};
            applyStimulus("random", rf, rw, ra, rb, 64'h0, 1'b0, i % 2);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
